// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the core/DMA memory arbiter.
package mem_arb_pkg;

  // State encodings kept as plain constants so legacy code can compare raw bits.
  localparam logic [1:0] ST_ARB   = 2'd0;
  localparam logic [1:0] ST_LOCK1 = 2'd1;
  localparam logic [1:0] ST_YIELD = 2'd2;

  typedef enum logic [1:0] {
    ARB   = ST_ARB,
    LOCK1 = ST_LOCK1,
    YIELD = ST_YIELD
  } arb_state_e;

  localparam int PORT_CORE = 0;
  localparam int PORT_DMA  = 1;

  localparam int BE_W   = 4;
  localparam int DATA_W = 32;

endpackage

// File: rtl/mem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module sat_counter #(
  parameter int W     = 3,
  parameter int LIMIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         at_limit
);

  assign at_limit = (count == W'(LIMIT));

  // Count up until LIMIT, hold there; clear wins over a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !at_limit) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of the unified instruction/data memory.
// Port 0 (core) has fixed priority; port 1 (DMA) gets a starvation override
// and bounded locked bursts followed by a one-cycle yield to the core.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 10,
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_BURST    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [BE_W-1:0]   p0_be,
  input  logic [DATA_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [BE_W-1:0]   p1_be,
  input  logic [DATA_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  input  logic              p1_lock,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [BE_W-1:0]   mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              owner
);

  localparam int WAIT_W  = $clog2(STARVE_LIMIT + 1);
  localparam int BURST_W = $clog2(MAX_BURST + 1);

  arb_state_e          state;
  arb_state_e          state_nxt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                wait_full;
  logic [BURST_W-1:0]  burst_cnt;
  logic                burst_inc;
  logic                burst_clr;
  logic                burst_last;
  logic                unused_burst_full;
  logic [DATA_W-1:0]   sel_addr;
  logic                unused_addr_bits;

  // Grant decision from registered state and current requests only.
  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (!rst) begin
      case (state)
        ARB: begin
          if (p1_req && (!p0_req || wait_full)) p1_gnt = 1'b1;
          else if (p0_req)                      p0_gnt = 1'b1;
        end
        LOCK1:   p1_gnt = p1_req;
        YIELD:   p0_gnt = p0_req;
        default: begin
          p0_gnt = 1'b0;
          p1_gnt = 1'b0;
        end
      endcase
    end
  end

  assign owner = p1_gnt ? 1'(PORT_DMA) : 1'(PORT_CORE);

  // The grant that brings the burst count to MAX_BURST is the last of the burst.
  assign burst_last = p1_gnt && (burst_cnt == BURST_W'(MAX_BURST - 1));

  // Next-state logic for lock ownership and the forced yield.
  always_comb begin
    state_nxt = state;
    case (state)
      ARB:     if (p1_gnt && p1_lock) state_nxt = LOCK1;
      LOCK1: begin
        if (!p1_lock)        state_nxt = ARB;
        else if (burst_last) state_nxt = YIELD;
      end
      YIELD:   state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ARB;
    else     state <= state_nxt;
  end

  sat_counter #(.W(WAIT_W), .LIMIT(STARVE_LIMIT)) u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .inc      (p1_req && !p1_gnt),
    .clr      (p1_gnt),
    .count    (wait_cnt),
    .at_limit (wait_full)
  );

  // Burst count starts at 1 on the locking grant in ARB; cleared on yield or lock release.
  assign burst_inc = p1_gnt && (((state == ARB) && p1_lock) || (state == LOCK1));
  assign burst_clr = (state == YIELD) || ((state == LOCK1) && !p1_lock);

  sat_counter #(.W(BURST_W), .LIMIT(MAX_BURST)) u_burst_cnt (
    .clk      (clk),
    .rst      (rst),
    .inc      (burst_inc),
    .clr      (burst_clr),
    .count    (burst_cnt),
    .at_limit (unused_burst_full)
  );

  // Memory request mux: granted port, else port 0; idle cycles strobe nothing.
  always_comb begin
    sel_addr  = p0_addr;
    mem_wdata = p0_wdata;
    mem_be    = '0;
    mem_we    = 1'b0;
    if (p1_gnt) begin
      sel_addr  = p1_addr;
      mem_wdata = p1_wdata;
      mem_be    = p1_be;
      mem_we    = p1_we;
    end else if (p0_gnt) begin
      mem_be    = p0_be;
      mem_we    = p0_we;
    end
  end

  assign mem_addr = sel_addr[ADDR_W+1:2];

  // Byte-lane and out-of-range address bits are deliberately ignored.
  assign unused_addr_bits = ^{p0_addr[DATA_W-1:ADDR_W+2], p0_addr[1:0],
                              p1_addr[DATA_W-1:ADDR_W+2], p1_addr[1:0]};

  // Read-data valid follows a read grant by one cycle (synchronous memory).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
    end else begin
      p0_rvalid <= p0_gnt && !p0_we;
      p1_rvalid <= p1_gnt && !p1_we;
    end
  end

  assign p0_rdata = mem_rdata;
  assign p1_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed per-cycle grant expectations.
module tb_mem_arbiter;

  localparam int ADDR_W = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p0_we;
  logic [3:0]  p0_be;
  logic [31:0] p0_addr, p0_wdata;
  logic        p0_gnt, p0_rvalid;
  logic [31:0] p0_rdata;
  logic        p1_req, p1_we, p1_lock;
  logic [3:0]  p1_be;
  logic [31:0] p1_addr, p1_wdata;
  logic        p1_gnt, p1_rvalid;
  logic [31:0] p1_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        owner;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(4), .MAX_BURST(8)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_be(p0_be), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_be(p1_be), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_lock(p1_lock), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
    .p1_rdata(p1_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner(owner)
  );

  // Synchronous-read memory stand-in: data encodes the word address it was read from.
  always @(posedge clk) mem_rdata <= {16'hA5A5, 6'd0, mem_addr};

  typedef struct {
    logic [8*12-1:0] tag;
    bit              g0, g1, we;
    logic [3:0]      be;
    logic [ADDR_W-1:0] addr;
    logic [31:0]     wdata;
    bit              v0, v1;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] rq0[$];
  logic [31:0] rq1[$];
  int          checks = 0;
  int          errors = 0;
  bit          pend0 = 1'b0;
  bit          pend1 = 1'b0;
  exp_t        mon_e;
  logic [31:0] mon_d;

  task automatic p0_set(input bit req, input bit we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd);
    p0_req = req; p0_we = we; p0_addr = addr; p0_be = be; p0_wdata = wd;
  endtask

  task automatic p1_set(input bit req, input bit we, input bit lock, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd);
    p1_req = req; p1_we = we; p1_lock = lock; p1_addr = addr; p1_be = be; p1_wdata = wd;
  endtask

  // Queue this cycle's expected outputs for the current inputs, then advance one cycle.
  task automatic step(input logic [8*12-1:0] tag, input bit eg0, input bit eg1);
    exp_t e;
    e.tag   = tag;
    e.g0    = eg0;
    e.g1    = eg1;
    e.we    = (eg0 && p0_we) || (eg1 && p1_we);
    e.be    = eg1 ? p1_be : (eg0 ? p0_be : 4'b0000);
    e.addr  = eg1 ? p1_addr[11:2] : p0_addr[11:2];
    e.wdata = eg1 ? p1_wdata : p0_wdata;
    if (rst) begin
      e.v0 = 1'b0;
      e.v1 = 1'b0;
      rq0.delete();
      rq1.delete();
      pend0 = 1'b0;
      pend1 = 1'b0;
    end else begin
      e.v0  = pend0;
      e.v1  = pend1;
      pend0 = eg0 && !p0_we;
      pend1 = eg1 && !p1_we;
      if (pend0) rq0.push_back({16'hA5A5, 6'd0, p0_addr[11:2]});
      if (pend1) rq1.push_back({16'hA5A5, 6'd0, p1_addr[11:2]});
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare the DUT against the oldest expectation each falling edge.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (p0_gnt !== mon_e.g0 || p1_gnt !== mon_e.g1 || owner !== mon_e.g1 ||
          mem_we !== mon_e.we || mem_be !== mon_e.be || mem_addr !== mon_e.addr ||
          (mon_e.we && mem_wdata !== mon_e.wdata) ||
          p0_rvalid !== mon_e.v0 || p1_rvalid !== mon_e.v1) begin
        errors++;
        $display("FAIL %0s: got gnt=%b/%b owner=%b we=%b be=%b addr=%h wdata=%h rvalid=%b/%b, want gnt=%b/%b owner=%b we=%b be=%b addr=%h wdata=%h rvalid=%b/%b",
                 mon_e.tag, p0_gnt, p1_gnt, owner, mem_we, mem_be, mem_addr, mem_wdata,
                 p0_rvalid, p1_rvalid, mon_e.g0, mon_e.g1, mon_e.g1, mon_e.we, mon_e.be,
                 mon_e.addr, mon_e.wdata, mon_e.v0, mon_e.v1);
      end
      if (mon_e.v0 && p0_rvalid) begin
        checks++;
        if (rq0.size() == 0) begin
          errors++;
          $display("FAIL %0s p0_rdata: got %h, no read outstanding", mon_e.tag, p0_rdata);
        end else begin
          mon_d = rq0.pop_front();
          if (p0_rdata !== mon_d) begin
            errors++;
            $display("FAIL %0s p0_rdata: got %h want %h", mon_e.tag, p0_rdata, mon_d);
          end
        end
      end
      if (mon_e.v1 && p1_rvalid) begin
        checks++;
        if (rq1.size() == 0) begin
          errors++;
          $display("FAIL %0s p1_rdata: got %h, no read outstanding", mon_e.tag, p1_rdata);
        end else begin
          mon_d = rq1.pop_front();
          if (p1_rdata !== mon_d) begin
            errors++;
            $display("FAIL %0s p1_rdata: got %h want %h", mon_e.tag, p1_rdata, mon_d);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    p0_set(0, 0, 32'h0, 4'h0, 32'h0);
    p1_set(0, 0, 0, 32'h0, 4'h0, 32'h0);
    @(posedge clk);
    #1;

    // Reset holds both grants low even with both ports requesting.
    p0_set(1, 0, 32'h10, 4'hF, 32'h0);
    p1_set(1, 0, 0, 32'h80, 4'hF, 32'h0);
    step("rst_hold", 0, 0);
    step("rst_hold", 0, 0);
    rst = 1'b0;

    // Core read alone: word address 4, data one cycle later.
    p1_set(0, 0, 0, 32'h0, 4'h0, 32'h0);
    p0_set(1, 0, 32'h10, 4'hF, 32'h0);
    step("core_rd", 1, 0);
    p0_set(0, 0, 32'h0, 4'h0, 32'h0);
    step("core_rd_rv", 0, 0);

    // Contention: four core grants, then the starving DMA port wins once.
    p0_set(1, 0, 32'h40, 4'hF, 32'h0);
    p1_set(1, 0, 0, 32'h80, 4'hF, 32'h0);
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) step("contend_p0", 1, 0);
      step("contend_p1", 0, 1);
    end
    p0_set(0, 0, 32'h0, 4'h0, 32'h0);
    p1_set(0, 0, 0, 32'h0, 4'h0, 32'h0);
    step("drain1", 0, 0);

    // DMA partial write: no read-valid follows.
    p1_set(1, 1, 0, 32'h20, 4'b0011, 32'hDEADBEEF);
    step("p1_wr", 0, 1);
    p1_set(0, 0, 0, 32'h0, 4'h0, 32'h0);
    step("p1_wr_norv", 0, 0);

    // Locked burst under core pressure: 8 DMA grants, yield, starvation, re-lock.
    p0_set(1, 0, 32'h44, 4'hF, 32'h0);
    p1_set(1, 0, 1, 32'h100, 4'hF, 32'h0);
    for (int k = 0; k < 4; k++) step("lb_starve", 1, 0);
    for (int k = 0; k < 8; k++) step("lb_burst", 0, 1);
    step("lb_yield", 1, 0);
    for (int k = 0; k < 3; k++) step("lb_restarve", 1, 0);
    step("lb_relock", 0, 1);
    step("lb_locked", 0, 1);
    p1_set(1, 0, 0, 32'h100, 4'hF, 32'h0);
    step("lb_unlock", 0, 1);
    p1_set(0, 0, 0, 32'h0, 4'h0, 32'h0);
    step("lb_after", 1, 0);
    p0_set(0, 0, 32'h0, 4'h0, 32'h0);
    step("drain2", 0, 0);

    // Lock drop mid-burst; an idle locked cycle still blocks the core.
    p1_set(1, 0, 1, 32'h180, 4'hF, 32'h0);
    step("ld_first", 0, 1);
    p0_set(1, 0, 32'h48, 4'hF, 32'h0);
    p1_set(0, 0, 1, 32'h180, 4'hF, 32'h0);
    step("ld_idle", 0, 0);
    p1_set(1, 0, 1, 32'h180, 4'hF, 32'h0);
    step("ld_burst", 0, 1);
    step("ld_burst", 0, 1);
    p1_set(0, 0, 0, 32'h0, 4'h0, 32'h0);
    step("ld_drop", 0, 0);
    step("ld_p0", 1, 0);
    p0_set(0, 0, 32'h0, 4'h0, 32'h0);
    step("drain3", 0, 0);

    // Reset during a locked burst (burst count 3): grants and strobes drop at once.
    p1_set(1, 0, 1, 32'h1C0, 4'hF, 32'h0);
    for (int k = 0; k < 3; k++) step("rm_burst", 0, 1);
    p0_set(1, 0, 32'h10, 4'hF, 32'h0);
    p1_set(1, 1, 1, 32'h1C0, 4'hF, 32'h12345678);
    rst = 1'b1;
    step("rm_rst", 0, 0);
    step("rm_rst", 0, 0);
    rst = 1'b0;
    step("rm_post", 1, 0);
    p0_set(0, 0, 32'h0, 4'h0, 32'h0);
    p1_set(0, 0, 0, 32'h0, 4'h0, 32'h0);
    step("drain4", 0, 0);
    step("drain4", 0, 0);

    @(posedge clk);
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0 || rq0.size() != 0 || rq1.size() != 0) begin
      errors++;
      $display("FAIL leftovers: exp=%0d rq0=%0d rq1=%0d, want all 0",
               exp_q.size(), rq0.size(), rq1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single unified instruction/data memory between two requesters: port 0 is the multicycle core (fetch, load, store), port 1 is the loader/debug DMA port.
- Sits between the core's address/write-data muxing and the memory.
- Core has fixed priority with zero added latency; port 1 gets a starvation guarantee and bounded locked bursts.
- Core control holds its current state while p0_req is high and p0_gnt is low.

Parameters:
ADDR_W, 10, word-address width driven to memory (memory depth is 2**ADDR_W words)
STARVE_LIMIT, 4, cycles port 1 may wait while requesting before it overrides port 0
MAX_BURST, 8, maximum consecutive locked port-1 grants before a forced yield

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
p0_req  in  1  core requests an access this cycle
p0_we  in  1  1 = write, 0 = read
p0_be  in  4  byte enables for writes
p0_addr  in  32  byte address; bits [ADDR_W+1:2] are used
p0_wdata  in  32  write data
p0_gnt  out  1  access accepted this cycle (combinational)
p0_rvalid  out  1  read data valid (registered)
p0_rdata  out  32  read data
p1_req, p1_we, p1_be, p1_addr, p1_wdata  in  same as port 0  DMA access
p1_lock  in  1  hold ownership for consecutive accesses
p1_gnt, p1_rvalid, p1_rdata  out  same as port 0
mem_addr  out  ADDR_W  word address to memory
mem_we  out  1  memory write strobe
mem_be  out  4  memory byte enables
mem_wdata  out  32  memory write data
mem_rdata  in  32  synchronous-read data, valid one cycle after address
owner  out  1  port being granted this cycle (0 when idle)

Behaviour:
- Reset (async, rst=1): state=ARB, wait_cnt=0, burst_cnt=0, p0_rvalid=p1_rvalid=0. While rst=1, p0_gnt=p1_gnt=0, mem_we=0, mem_be=0, owner=0. Any in-flight rvalid is dropped.
- At most one grant per cycle, and only to a requesting port.
- mem_addr/mem_be/mem_wdata come from the granted port, else from port 0.
- mem_we = gnt & we of the granted port. Idle cycles give mem_we=0 and mem_be=0.
- Read latency is 1: pX_rvalid <= pX_gnt & ~pX_we. pX_rdata = mem_rdata, passed through for both ports. Write gives no rvalid.
- wait_cnt: increments each cycle p1_req & ~p1_gnt, saturating at STARVE_LIMIT. Clears on p1_gnt.
- State ARB:
  - p1 is granted if p1_req & (~p0_req | wait_cnt==STARVE_LIMIT); otherwise p0_req is granted.
  - p1_gnt & p1_lock -> LOCK1 with burst_cnt=1.
- State LOCK1:
  - p0 is never granted. p1 is granted whenever p1_req; each grant increments burst_cnt.
  - p1_lock=0 -> ARB; the grant in that cycle still follows LOCK1 rules.
  - burst_cnt==MAX_BURST and p1_lock=1 -> YIELD.
  - p1_req=0 with p1_lock=1 leaves memory idle and stays in LOCK1.
- State YIELD:
  - p0 is granted if p0_req; p1 is not granted. Lasts one cycle, then -> ARB.
  - burst_cnt clears.
  - If p1_lock is still high, the next p1 grant in ARB re-enters LOCK1.
- Simultaneous p1_gnt and a wait_cnt update: clear wins.
- Address bits [1:0] are ignored; no misalignment fault.
- owner and state-dependent grant logic are purely combinational from registered state and current requests. There is no combinational path from mem_rdata to any grant.

Decomposition:
- Package mem_arb_pkg:
  - State enum {ARB, LOCK1, YIELD} (2 bits).
  - Port index constants PORT_CORE=0, PORT_DMA=1.
  - Byte-enable width constant 4.
- One sub-module is natural: sat_counter (width/limit parameters; inc, clr, at_limit). It is instantiated twice, for wait_cnt and burst_cnt.

Test Plan:
- Reset mid-burst: assert rst in LOCK1 with burst_cnt=3 -> same cycle gnt=0, mem_we=0; after release state=ARB, p1_rvalid=0.
- Core read alone: p0_req=1, p0_we=0, p0_addr=0x0000_0010 -> p0_gnt=1 same cycle, mem_addr=4; next cycle p0_rvalid=1, p0_rdata=mem_rdata.
- Contention: p0_req and p1_req held high continuously -> p0 granted for 4 cycles, p1 granted on cycle 5, wait_cnt=0 after; pattern repeats.
- Locked burst: p1_lock=1 and p1_req=1 for 12 cycles, p0_req=1 -> p1 granted 8 consecutive cycles, YIELD grants p0 once, then p1 re-locks.
- Write with byte enables: p1 write, be=4'b0011, wdata=0xDEADBEEF, addr=0x20, p0 idle -> mem_we=1, mem_be=0011, mem_addr=8; no p1_rvalid.
- Lock drop mid-burst: p1_lock falls after 3 grants -> state=ARB next cycle; pending p0_req granted that cycle.
